// File: rtl/branch_resolve_unit_if.sv
// Request/result bus of the branch resolve unit: one request channel, one result channel, flush and stats.
interface branch_resolve_unit_if #(
  parameter int WIDTH      = 32,
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 16
);
  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // sender holds valid and data until then, and ready may depend on valid.
  logic                  In_Valid;
  logic                  In_Ready;
  logic [WIDTH-1:0]      InA;
  logic [WIDTH-1:0]      InB;
  logic [2:0]            Control;
  logic [PC_WIDTH-1:0]   PC;
  logic [15:0]           Offset;
  logic                  Pred_Taken;
  logic                  Flush;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic                  Taken;
  logic                  Mispredict;
  logic [PC_WIDTH-1:0]   Redirect_PC;
  logic [STAT_WIDTH-1:0] Stat_Branches;
  logic [STAT_WIDTH-1:0] Stat_Mispredicts;

  modport master (
    output In_Valid, InA, InB, Control, PC, Offset, Pred_Taken, Flush, Out_Ready,
    input  In_Ready, Out_Valid, Taken, Mispredict, Redirect_PC,
           Stat_Branches, Stat_Mispredicts
  );

  modport slave (
    input  In_Valid, InA, InB, Control, PC, Offset, Pred_Taken, Flush, Out_Ready,
    output In_Ready, Out_Valid, Taken, Mispredict, Redirect_PC,
           Stat_Branches, Stat_Mispredicts
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 captures operands and both candidate PCs, S2 resolves and holds the result.
// Define BRU_STATS_EN to build the saturating branch/mispredict counters; otherwise the Stat_* ports read 0.
module branch_resolve_unit #(
  parameter int WIDTH      = 32,
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  branch_resolve_unit_if.slave  bus
);

  logic                s2_adv;
  logic                s1_adv;
  logic                in_fire;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] offset_bytes;

  logic                s1_valid;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;
  logic [2:0]          s1_ctl;
  logic                s1_pred;
  logic [PC_WIDTH-1:0] s1_pc4;
  logic [PC_WIDTH-1:0] s1_tgt;

  logic                cond_taken;
  logic                a_neg;
  logic                a_zero;

  logic                out_valid;
  logic                out_taken;
  logic                out_mis;
  logic [PC_WIDTH-1:0] out_redirect;

  assign s2_adv       = !out_valid || bus.Out_Ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.In_Ready = s1_adv && !bus.Flush;
  assign in_fire      = bus.In_Valid && bus.In_Ready;

  assign pc_plus4     = bus.PC + PC_WIDTH'(4);
  assign offset_bytes = {{(PC_WIDTH-18){bus.Offset[15]}}, bus.Offset, 2'b00};

  always_ff @(posedge Clock) begin
    if (!Reset_n)       s1_valid <= 1'b0;
    else if (bus.Flush) s1_valid <= 1'b0;
    else if (s1_adv)    s1_valid <= bus.In_Valid;
  end

  // S1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge Clock) begin
    if (in_fire) begin
      s1_a    <= bus.InA;
      s1_b    <= bus.InB;
      s1_ctl  <= bus.Control;
      s1_pred <= bus.Pred_Taken;
      s1_pc4  <= pc_plus4;
      s1_tgt  <= pc_plus4 + offset_bytes;
    end
  end

  assign a_neg  = s1_a[WIDTH-1];
  assign a_zero = (s1_a == '0);

  always_comb begin
    cond_taken = 1'b0;
    case (s1_ctl)
      3'b000:  cond_taken = (s1_a == s1_b);
      3'b001:  cond_taken = (s1_a != s1_b);
      3'b010:  cond_taken = a_neg;
      3'b011:  cond_taken = !a_neg;
      3'b100:  cond_taken = !a_neg && !a_zero;
      3'b101:  cond_taken = a_neg || a_zero;
      3'b110:  cond_taken = ($signed(s1_a) < $signed(s1_b));
      default: cond_taken = (s1_a < s1_b);
    endcase
  end

  // Result registers only move when the consumer can take a new value.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      out_valid    <= 1'b0;
      out_taken    <= 1'b0;
      out_mis      <= 1'b0;
      out_redirect <= '0;
    end else if (bus.Flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_taken    <= cond_taken;
        out_mis      <= (cond_taken != s1_pred);
        out_redirect <= cond_taken ? s1_tgt : s1_pc4;
      end
    end
  end

  assign bus.Out_Valid   = out_valid;
  assign bus.Taken       = out_taken;
  assign bus.Mispredict  = out_mis;
  assign bus.Redirect_PC = out_redirect;

`ifdef BRU_STATS_EN
  logic                  out_fire;
  logic [STAT_WIDTH-1:0] stat_br;
  logic [STAT_WIDTH-1:0] stat_mp;

  // A result killed by Flush in the same cycle is not counted.
  assign out_fire = out_valid && bus.Out_Ready && !bus.Flush;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      stat_br <= '0;
      stat_mp <= '0;
    end else if (out_fire) begin
      if (stat_br != '1)            stat_br <= stat_br + 1'b1;
      if (out_mis && stat_mp != '1) stat_mp <= stat_mp + 1'b1;
    end
  end

  assign bus.Stat_Branches    = stat_br;
  assign bus.Stat_Mispredicts = stat_mp;
`else
  assign bus.Stat_Branches    = '0;
  assign bus.Stat_Mispredicts = '0;
`endif

endmodule
